// File: rtl/spu_event_encoder.sv
// Event encoder: buffers masked single-cycle event pulses per source and
// serialises them round-robin into one {PORT_ID, src+1} event ID per clock.
module spu_event_encoder #(
  parameter int         NUM_SRC    = 5,
  parameter int         PEND_WIDTH = 4,
  parameter logic [3:0] PORT_ID    = 4'h1,
  parameter int         DROP_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [NUM_SRC-1:0]    src_mask_i,
  input  logic [NUM_SRC-1:0]    src_event_i,
  output logic [7:0]            e_id_o,
  output logic [DROP_WIDTH-1:0] drop_cnt_o,
  output logic                  busy_o
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int DW1   = DROP_WIDTH + 1;

  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(NUM_SRC - 1);
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);

  logic [PEND_WIDTH-1:0] pend_q [NUM_SRC];
  logic [PEND_WIDTH-1:0] pend_d [NUM_SRC];
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [7:0]            e_id_q, e_id_d;
  logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic [NUM_SRC-1:0] inc;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] gnt;
  logic [NUM_SRC-1:0] drop;
  logic               gnt_valid;
  logic [PTR_W-1:0]   gnt_idx;
  logic [DROP_WIDTH:0] drop_sum;

  assign inc = src_event_i & src_mask_i & {NUM_SRC{en_i}};

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i] = (pend_q[i] != '0);
    end
  end

  // Two-pass search: indices at or above the pointer first, then wrap to the
  // lowest requester below it. Only registered counts are considered.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!gnt_valid && req[i] && (PTR_W'(i) >= ptr_q)) begin
        gnt_valid = 1'b1;
        gnt_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!gnt_valid && req[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      gnt[i] = gnt_valid && (gnt_idx == PTR_W'(i));
    end
  end

  // Pending counters: simultaneous capture and grant cancel, so a full
  // counter being granted never drops the incoming event.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_d[i] = pend_q[i];
      drop[i]   = 1'b0;
      case ({inc[i], gnt[i]})
        2'b10: begin
          if (pend_q[i] == PEND_MAX) begin
            drop[i] = 1'b1;
          end else begin
            pend_d[i] = pend_q[i] + PEND_ONE;
          end
        end
        2'b01:   pend_d[i] = pend_q[i] - PEND_ONE;
        default: pend_d[i] = pend_q[i];
      endcase
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    e_id_d = 8'h00;
    if (gnt_valid) begin
      ptr_d  = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PTR_ONE;
      e_id_d = {PORT_ID, 4'(gnt_idx) + 4'd1};
    end
  end

  // Drop counter sums all sources in one extra bit, then saturates.
  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < NUM_SRC; i++) begin
      drop_sum = drop_sum + DW1'(drop[i]);
    end
    drop_cnt_d = (drop_sum > {1'b0, DROP_MAX}) ? DROP_MAX : drop_sum[DROP_WIDTH-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q     <= '{default: '0};
      ptr_q      <= '0;
      e_id_q     <= 8'h00;
      drop_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      ptr_q      <= ptr_d;
      e_id_q     <= e_id_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign e_id_o     = e_id_q;
  assign drop_cnt_o = drop_cnt_q;
  assign busy_o     = |req;

endmodule
